// File: rtl/neuron_addr_gen.sv
// neuron_addr_gen: walks a fully connected layer, issuing one registered
// (input addr, weight addr, neuron index) triple per accepted read. Optional bias term: AG_BIAS_EN.
`default_nettype none

module neuron_addr_gen #(
  parameter int N_INPUTS  = 4,
  parameter int N_NEURONS = 3,
  parameter int IN_AW     = 3,
  parameter int W_AW      = 4,
  parameter int N_W       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             AG_rst,
  input  logic             AG_read,
  output logic [IN_AW-1:0] in_addr,
  output logic [W_AW-1:0]  w_addr,
  output logic [N_W-1:0]   neuron_idx,
  output logic             addr_valid,
  output logic             last_in,
  output logic             done
);

`ifdef AG_BIAS_EN
  localparam int c_T = N_INPUTS + 1;
`else
  localparam int c_T = N_INPUTS;
`endif

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t           state_q;
  logic [IN_AW-1:0] i_q;
  logic [N_W-1:0]   n_q;
  logic [W_AW-1:0]  w_q;

  logic last_term_d;
  logic final_term_d;
  logic accept_d;

  assign last_term_d  = (i_q == IN_AW'(c_T - 1));
  assign final_term_d = last_term_d && (n_q == N_W'(N_NEURONS - 1));
  assign accept_d     = AG_read && (state_q == S_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RUN;
      i_q        <= '0;
      n_q        <= '0;
      w_q        <= '0;
      in_addr    <= '0;
      w_addr     <= '0;
      neuron_idx <= '0;
      addr_valid <= 1'b0;
      last_in    <= 1'b0;
      done       <= 1'b0;
    end else if (AG_rst) begin
      // Address outputs deliberately keep their last values across a restart.
      state_q    <= S_RUN;
      i_q        <= '0;
      n_q        <= '0;
      w_q        <= '0;
      addr_valid <= 1'b0;
      last_in    <= 1'b0;
      done       <= 1'b0;
    end else begin
      addr_valid <= accept_d;
      last_in    <= accept_d && last_term_d;
      if (accept_d) begin
        in_addr    <= i_q;
        w_addr     <= w_q;
        neuron_idx <= n_q;
        if (final_term_d) begin
          // Freeze counters on the last term so the layer never wraps.
          state_q <= S_DONE;
          done    <= 1'b1;
        end else begin
          w_q <= w_q + 1'b1;
          if (last_term_d) begin
            i_q <= '0;
            n_q <= n_q + 1'b1;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neuron_addr_gen.sv
// Table-driven bench for neuron_addr_gen (default or AG_BIAS_EN build).
`default_nettype none

module tb_neuron_addr_gen;

  localparam int N_INPUTS  = 4;
  localparam int N_NEURONS = 3;
`ifdef AG_BIAS_EN
  localparam int T = N_INPUTS + 1;
`else
  localparam int T = N_INPUTS;
`endif
  localparam int TOTAL = N_NEURONS * T;

  typedef struct {
    logic       rd;
    logic       rst;
    logic [2:0] ia;
    logic [3:0] wa;
    logic [1:0] ni;
    logic       v;
    logic       li;
    logic       dn;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       AG_rst = 1'b0;
  logic       AG_read = 1'b0;
  logic [2:0] in_addr;
  logic [3:0] w_addr;
  logic [1:0] neuron_idx;
  logic       addr_valid;
  logic       last_in;
  logic       done;

  int n_pass = 0;
  int n_total = 0;

  vec_t vq[$];

  neuron_addr_gen #(
    .N_INPUTS (N_INPUTS),
    .N_NEURONS(N_NEURONS),
    .IN_AW    (3),
    .W_AW     (4),
    .N_W      (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .AG_rst    (AG_rst),
    .AG_read   (AG_read),
    .in_addr   (in_addr),
    .w_addr    (w_addr),
    .neuron_idx(neuron_idx),
    .addr_valid(addr_valid),
    .last_in   (last_in),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic vec_t term(input int k);
    vec_t v;
    v.rd  = 1'b1;
    v.rst = 1'b0;
    v.ia  = 3'(k % T);
    v.wa  = 4'(k);
    v.ni  = 2'(k / T);
    v.v   = 1'b1;
    v.li  = ((k % T) == T - 1);
    v.dn  = (k == TOTAL - 1);
    return v;
  endfunction

  function automatic vec_t hold(input logic rd, input logic rst, input vec_t p, input logic dn);
    vec_t v;
    v     = p;
    v.rd  = rd;
    v.rst = rst;
    v.v   = 1'b0;
    v.li  = 1'b0;
    v.dn  = dn;
    return v;
  endfunction

  task automatic check(input string name, input vec_t e);
    logic [11:0] act;
    logic [11:0] exp;
    act = {in_addr, w_addr, neuron_idx, addr_valid, last_in, done};
    exp = {e.ia, e.wa, e.ni, e.v, e.li, e.dn};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got ia/wa/ni/v/li/dn=%0d/%0d/%0d/%b/%b/%b, expected %0d/%0d/%0d/%b/%b/%b",
                  name, in_addr, w_addr, neuron_idx, addr_valid, last_in, done,
                  e.ia, e.wa, e.ni, e.v, e.li, e.dn);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t zero;
    zero = hold(1'b0, 1'b0, term(0), 1'b0);

    step();
    check("reset_state", zero);
    reset = 1'b1;

    // Full layer, back to back.
    for (int k = 0; k < TOTAL; k++) vq.push_back(term(k));
    // Reads after DONE are ignored; outputs hold the final term.
    for (int k = 0; k < 3; k++) vq.push_back(hold(1'b1, 1'b0, term(TOTAL - 1), 1'b1));
    // Restart, five reads, restart, one read.
    vq.push_back(hold(1'b0, 1'b1, term(TOTAL - 1), 1'b0));
    for (int k = 0; k < 5; k++) vq.push_back(term(k));
    vq.push_back(hold(1'b0, 1'b1, term(4), 1'b0));
    vq.push_back(term(0));
    // Restart wins over a simultaneous read.
    vq.push_back(term(1));
    vq.push_back(hold(1'b1, 1'b1, term(1), 1'b0));
    vq.push_back(term(0));

    for (int j = 0; j < vq.size(); j++) begin
      AG_read = vq[j].rd;
      AG_rst  = vq[j].rst;
      step();
      check($sformatf("vec%0d", j), vq[j]);
    end

    // Asynchronous reset between edges after six reads.
    AG_read = 1'b0;
    AG_rst  = 1'b1;
    step();
    AG_rst  = 1'b0;
    AG_read = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("pre_reset_read%0d", k), term(k));
    end
    AG_read = 1'b0;
    step();
    check("idle_hold", hold(1'b0, 1'b0, term(5), 1'b0));
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", zero);
    #2;
    reset = 1'b1;
    AG_read = 1'b1;
    step();
    check("first_after_reset", term(0));
    AG_read = 1'b0;
    step();
    check("strobe_drops", hold(1'b0, 1'b0, term(0), 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/neuron_addr_gen.md
# neuron_addr_gen

Address generator driven by the `ControlUnit` through its `AG_rst` and `AG_read` outputs. Each accepted read request produces one registered (input address, weight address, neuron index) triple. The triples walk a fully connected layer neuron by neuron, so the downstream ALU can multiply-accumulate one term per cycle. The block flags the last term of each neuron and the end of the layer.

## Interface
Parameters:
- `N_INPUTS`, default 4: inputs per neuron, excluding bias.
- `N_NEURONS`, default 3: neurons in the layer.
- `IN_AW`, default 3: input address width; must hold `N_INPUTS`.
- `W_AW`, default 4: weight address width; must hold `N_NEURONS*(N_INPUTS+1)-1`.
- `N_W`, default 2: neuron index width; must hold `N_NEURONS-1`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `AG_rst` in 1: synchronous restart to the first term of neuron 0.
- `AG_read` in 1: request the next address triple.
- `in_addr` out `IN_AW`: input memory address.
- `w_addr` out `W_AW`: weight memory address.
- `neuron_idx` out `N_W`: neuron the current term belongs to.
- `addr_valid` out 1: one-cycle strobe; the address triple is valid.
- `last_in` out 1: qualifies `addr_valid`; marks the final term of the current neuron.
- `done` out 1: sticky; the layer is fully issued.

## Operation
- Internal state:
  - input counter `i`;
  - neuron counter `n`;
  - running weight counter `w`, incremented each step. There is no multiplier.
  - two-state FSM: RUN, DONE.
- Terms per neuron: `T = N_INPUTS`, or `N_INPUTS+1` with `AG_BIAS_EN`.
- Accepted read (`AG_read=1`, `AG_rst=0`, state RUN), registered on the edge:
  - `in_addr<=i`, `w_addr<=w`, `neuron_idx<=n`;
  - `addr_valid<=1`;
  - `last_in<=(i==T-1)`.
- Counter advance on an accepted read:
  - `w<=w+1`;
  - if `i==T-1`: `i<=0`, `n<=n+1`;
  - otherwise `i<=i+1`.
- Final term (`i==T-1` and `n==N_NEURONS-1`):
  - FSM goes to DONE;
  - `done<=1` on the same edge as the final `addr_valid`;
  - counters are not advanced further, so there is no wrap.
- DONE: `AG_read` is ignored; `addr_valid` stays 0; address outputs hold their last values.
- `AG_rst=1`:
  - `i`, `n`, `w` go to 0; FSM goes to RUN;
  - `done<=0`, `addr_valid<=0`, `last_in<=0`;
  - address outputs hold their values.
  - `AG_rst` has priority over a simultaneous `AG_read`; that read is dropped.
- `AG_read` held high: one term issues per cycle, back to back.
- Reset values (`reset=0`): every output and every counter is 0; FSM is RUN.

## Timing
- Latency: outputs change on the edge that samples `AG_read`, i.e. visible one cycle after the request. All outputs are registered.
- `addr_valid` and `last_in` are single-cycle unless reads are back to back.
- Throughput: one term per cycle.
- A full layer takes `N_NEURONS*T` accepted reads.
- `reset` assertion mid-operation clears all outputs immediately, without waiting for `clk`.
- `reset` deassertion: the block is ready at the first rising edge after deassertion.
- `AG_rst` mid-layer: takes effect at the next edge; the first read after it yields 0/0/0.

## Configuration
- `AG_BIAS_EN` defined: each neuron gets one extra term, the bias term.
  - Bias term: `in_addr=N_INPUTS`, the constant-1 input slot.
  - `w_addr` continues sequentially, so the weight stride is `N_INPUTS+1`.
  - `last_in` marks the bias term.
- `AG_BIAS_EN` undefined:
  - `T=N_INPUTS`;
  - `in_addr` never reaches `N_INPUTS`;
  - weight stride is `N_INPUTS`.

## Test plan
1. Default parameters, no bias: release reset, hold `AG_read` for 12 cycles.
   - `in_addr`: 0,1,2,3 repeating.
   - `w_addr`: 0..11.
   - `neuron_idx`: 0×4, 1×4, 2×4.
   - `last_in` on valid strobes 4, 8, 12.
   - `done` rises with strobe 12.
2. After case 1, pulse `AG_read` 3 times.
   - `addr_valid` stays 0.
   - Outputs hold 3/11/2.
   - `done` stays 1.
3. Five reads, then `AG_rst`, then one read.
   - That read yields 0/0/0 with `last_in=0`.
   - `done=0`.
4. `AG_rst` and `AG_read` high in the same cycle mid-layer: `addr_valid=0` that edge; the next read yields 0/0/0.
5. Drop `reset` low between edges after 6 reads: all outputs 0 before the next edge; after release, the first read yields 0/0/0.
6. `AG_BIAS_EN` defined, 15 back-to-back reads.
   - `in_addr`: 0,1,2,3,4 per neuron.
   - `w_addr`: 0..14.
   - `last_in` on strobes 5, 10, 15.
   - `done` rises with strobe 15.
